// File: rtl/floatingpointpkg.sv
// Shared floating-point types for the adder and its request-side issuer:
// the IEEE-754 single-precision view, the issuer state encoding and the counter width.
package floatingpointpkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GO   = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } issuer_state_t;

    localparam int ISSUER_CNT_W = 16;

    // Subtraction is performed by the adder as A + (-B).
    function automatic float apply_sub(float b, logic sub);
        float r;
        r      = b;
        r.sign = b.sign ^ sub;
        return r;
    endfunction

endpackage

// File: rtl/fp_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared only by reset.
module fp_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fp_add_issuer.sv
// Drives one operation at a time into a fixed-latency FP adder and returns the result.
// Optional statistics counters are built only when FP_ADD_ISSUER_STATS_EN is defined.
module fp_add_issuer
    import floatingpointpkg::*;
#(
    parameter int ADD_LATENCY = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  float                    ReqA,
    input  float                    ReqB,
    input  logic                    ReqSub,
    output float                    AddendA,
    output float                    AddendB,
    output logic                    Go,
    input  float                    Result,
    input  logic                    Zero,
    input  logic                    Inf,
    input  logic                    Nan,
    output logic                    RspValid,
    input  logic                    RspReady,
    output float                    RspResult,
    output logic                    RspZero,
    output logic                    RspInf,
    output logic                    RspNan,
    output logic                    Busy,
    output logic [ISSUER_CNT_W-1:0] IssueCount,
    output logic [ISSUER_CNT_W-1:0] NanCount,
    output issuer_state_t           DbgState
);

    generate
        if (ADD_LATENCY < 0 || ADD_LATENCY > 15) begin : g_bad_latency
            $error("fp_add_issuer: ADD_LATENCY must be within 0..15");
        end
    endgenerate

    localparam logic [3:0] CNT_LOAD = (ADD_LATENCY > 0) ? 4'(ADD_LATENCY - 1) : 4'd0;

    issuer_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    float          addend_a_q, addend_a_d;
    float          addend_b_q, addend_b_d;
    float          rsp_result_q, rsp_result_d;
    logic [2:0]    rsp_flags_q, rsp_flags_d;

    logic go;
    logic capture;
    logic accept;
    logic req_ready;
    logic rsp_valid;

    // Both handshakes transfer on a cycle where valid and ready are high together;
    // a valid, once raised, holds its payload until that transfer cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addend_a_d   = addend_a_q;
        addend_b_d   = addend_b_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        go           = 1'b0;
        capture      = 1'b0;
        accept       = 1'b0;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (ReqValid) begin
                    accept  = 1'b1;
                    state_d = GO;
                end
            end
            GO: begin
                go = 1'b1;
                if (ADD_LATENCY == 0) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                rsp_valid = 1'b1;
                req_ready = RspReady;
                if (RspReady) begin
                    if (ReqValid) begin
                        accept  = 1'b1;
                        state_d = GO;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            addend_a_d = ReqA;
            addend_b_d = apply_sub(ReqB, ReqSub);
        end
        if (capture) begin
            rsp_result_d = Result;
            rsp_flags_d  = {Zero, Inf, Nan};
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addend_a_q   <= '0;
            addend_b_q   <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addend_a_q   <= addend_a_d;
            addend_b_q   <= addend_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign ReqReady  = req_ready;
    assign Go        = go;
    assign RspValid  = rsp_valid;
    assign Busy      = (state_q != IDLE);
    assign AddendA   = addend_a_q;
    assign AddendB   = addend_b_q;
    assign RspResult = rsp_result_q;
    assign RspZero   = rsp_flags_q[2];
    assign RspInf    = rsp_flags_q[1];
    assign RspNan    = rsp_flags_q[0];
    assign DbgState  = state_q;

`ifdef FP_ADD_ISSUER_STATS_EN
    fp_sat_counter #(
        .W(ISSUER_CNT_W)
    ) u_issue_cnt (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .inc_i  (go),
        .count_o(IssueCount)
    );

    fp_sat_counter #(
        .W(ISSUER_CNT_W)
    ) u_nan_cnt (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .inc_i  (capture & Nan),
        .count_o(NanCount)
    );
`else
    assign IssueCount = '0;
    assign NanCount   = '0;
`endif

endmodule

// File: tb/tb_fp_add_issuer.sv
// Directed bench for fp_add_issuer: a 4-cycle adder instance and a combinational-adder instance.
module tb_fp_add_issuer;
    import floatingpointpkg::*;

`ifdef FP_ADD_ISSUER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [34:0] JUNK = {32'hDEADBEEF, 3'b111};

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    // 4-cycle-latency instance
    logic          ReqValid4, ReqReady4, ReqSub4, Go4, Zero4, Inf4, Nan4;
    logic          RspValid4, RspReady4, RspZero4, RspInf4, RspNan4, Busy4;
    logic [31:0]   ReqA4, ReqB4, AddendA4, AddendB4, Result4, RspResult4;
    logic [15:0]   IssueCount4, NanCount4;
    issuer_state_t DbgState4;

    // combinational-adder instance
    logic          ReqValid0, ReqReady0, ReqSub0, Go0, Zero0, Inf0, Nan0;
    logic          RspValid0, RspReady0, RspZero0, RspInf0, RspNan0, Busy0;
    logic [31:0]   ReqA0, ReqB0, AddendA0, AddendB0, Result0, RspResult0;
    logic [15:0]   IssueCount0, NanCount0;
    issuer_state_t DbgState0;

    fp_add_issuer #(.ADD_LATENCY(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid4), .ReqReady(ReqReady4),
        .ReqA(ReqA4), .ReqB(ReqB4), .ReqSub(ReqSub4), .AddendA(AddendA4), .AddendB(AddendB4),
        .Go(Go4), .Result(Result4), .Zero(Zero4), .Inf(Inf4), .Nan(Nan4),
        .RspValid(RspValid4), .RspReady(RspReady4), .RspResult(RspResult4),
        .RspZero(RspZero4), .RspInf(RspInf4), .RspNan(RspNan4), .Busy(Busy4),
        .IssueCount(IssueCount4), .NanCount(NanCount4), .DbgState(DbgState4)
    );

    fp_add_issuer #(.ADD_LATENCY(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid0), .ReqReady(ReqReady0),
        .ReqA(ReqA0), .ReqB(ReqB0), .ReqSub(ReqSub0), .AddendA(AddendA0), .AddendB(AddendB0),
        .Go(Go0), .Result(Result0), .Zero(Zero0), .Inf(Inf0), .Nan(Nan0),
        .RspValid(RspValid0), .RspReady(RspReady0), .RspResult(RspResult0),
        .RspZero(RspZero0), .RspInf(RspInf0), .RspNan(RspNan0), .Busy(Busy0),
        .IssueCount(IssueCount0), .NanCount(NanCount0), .DbgState(DbgState0)
    );

    // Toy adder: knows only the operand pairs used below; returns {result, zero, inf, nan}.
    function automatic logic [34:0] add_fn(input logic [31:0] a, input logic [31:0] b);
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
            return {32'h7FC00000, 3'b001};
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {32'h7F800000, 3'b010};
        if (a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 3'b000};
        if (a == 32'h3F800000 && b == 32'hBF800000) return {32'h00000000, 3'b100};
        if (a == 32'h40000000 && b == 32'h40000000) return {32'h40800000, 3'b000};
        return {32'h12345678, 3'b000};
    endfunction

    // Pipelined adder model: the sum appears 4 cycles after Go, junk otherwise.
    logic [34:0] pipe [4];
    initial for (int i = 0; i < 4; i++) pipe[i] = JUNK;
    always @(posedge Clock) begin
        pipe[0] <= Go4 ? add_fn(AddendA4, AddendB4) : JUNK;
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign {Result4, Zero4, Inf4, Nan4} = pipe[3];
    assign {Result0, Zero0, Inf0, Nan0} = Go0 ? add_fn(AddendA0, AddendB0) : JUNK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp_b;
        logic [31:0] exp_res;
        logic [2:0]  exp_flags;
    } vec_t;

    vec_t vecs [5];

    // Starts just after a negedge with dut4 idle; ends just after a negedge with dut4 idle.
    task automatic run_vec4(input vec_t v, input int idx);
        logic [6:1] go_mask, rsp_mask;
        int unstable;
        unstable  = 0;
        ReqA4     = v.a;
        ReqB4     = v.b;
        ReqSub4   = v.sub;
        ReqValid4 = 1'b1;
        RspReady4 = 1'b0;
        check($sformatf("v%0d_req_ready", idx), ReqReady4, 1);
        @(posedge Clock); #1;
        ReqValid4 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clock);
            go_mask[k]  = Go4;
            rsp_mask[k] = RspValid4;
            if (AddendA4 !== v.a || AddendB4 !== v.exp_b) unstable++;
        end
        check($sformatf("v%0d_addend_b", idx), AddendB4, v.exp_b);
        check($sformatf("v%0d_addend_unstable", idx), unstable, 0);
        check($sformatf("v%0d_go_timing", idx), {26'd0, go_mask}, 32'h01);
        check($sformatf("v%0d_rsp_timing", idx), {26'd0, rsp_mask}, 32'h20);
        check($sformatf("v%0d_result", idx), RspResult4, v.exp_res);
        check($sformatf("v%0d_flags", idx), {RspZero4, RspInf4, RspNan4}, v.exp_flags);
        RspReady4 = 1'b1;
        @(posedge Clock); #1;
        RspReady4 = 1'b0;
        @(negedge Clock);
        check($sformatf("v%0d_idle_after", idx), Busy4, 0);
    endtask

    initial begin
        int bad;
        logic [13:1] go_mask, rsp_mask;
        vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000, 3'b000};
        vecs[1] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h00000000, 3'b100};
        vecs[2] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h3F800000, 32'h7F800000, 3'b010};
        vecs[3] = '{32'h40000000, 32'hC0000000, 1'b1, 32'h40000000, 32'h40800000, 3'b000};
        vecs[4] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h3F800000, 32'h7FC00000, 3'b001};
        {ReqValid4, ReqSub4, RspReady4, ReqA4, ReqB4} = '0;
        {ReqValid0, ReqSub0, RspReady0, ReqA0, ReqB0} = '0;

        // reset values
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_busy", Busy4, 0);
        check("rst_req_ready", ReqReady4, 1);
        check("rst_go_rspvalid", {Go4, RspValid4}, 0);
        check("rst_addends", AddendA4 | AddendB4, 0);
        check("rst_rsp", {RspResult4[30:0], RspZero4, RspInf4, RspNan4}, 0);
        check("rst_counts", {IssueCount4, NanCount4}, 0);
        check("rst_state", 32'(DbgState4), 32'(IDLE));
        Reset = 1'b0;
        @(negedge Clock);

        for (int i = 0; i < 5; i++) run_vec4(vecs[i], i);
        check("tbl_issue_count", IssueCount4, STATS ? 5 : 0);
        check("tbl_nan_count", NanCount4, STATS ? 1 : 0);

        // backpressure: response held for 10+ cycles while a second request waits
        bad = 0;
        ReqA4 = 32'h3F800000; ReqB4 = 32'h40000000; ReqSub4 = 1'b0;
        ReqValid4 = 1'b1; RspReady4 = 1'b0;
        @(posedge Clock); #1;
        ReqA4 = 32'h40000000;
        for (int k = 1; k <= 16; k++) begin
            @(negedge Clock);
            if (k >= 2 && Go4 !== 1'b0) bad++;
            if (k >= 6 && (RspValid4 !== 1'b1 || RspResult4 !== 32'h40400000 ||
                           ReqReady4 !== 1'b0 || AddendA4 !== 32'h3F800000)) bad++;
        end
        check("bp_bad_cycles", bad, 0);
        check("bp_result", RspResult4, 32'h40400000);
        ReqValid4 = 1'b0; RspReady4 = 1'b1;
        @(posedge Clock); #1;
        RspReady4 = 1'b0;
        @(negedge Clock);
        check("bp_idle_after", Busy4, 0);

        // back-to-back: second request accepted in the HOLD cycle of the first
        ReqA4 = 32'h3F800000; ReqB4 = 32'h40000000; ReqSub4 = 1'b0;
        ReqValid4 = 1'b1; RspReady4 = 1'b0;
        @(posedge Clock); #1;
        ReqA4 = 32'h40000000; ReqB4 = 32'hC0000000; ReqSub4 = 1'b1;
        RspReady4 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge Clock);
            go_mask[k]  = Go4;
            rsp_mask[k] = RspValid4;
            if (k == 6) begin
                check("b2b_first_result", RspResult4, 32'h40400000);
                check("b2b_ready_in_hold", ReqReady4, 1);
                @(posedge Clock); #1;
                ReqValid4 = 1'b0;
            end
            if (k == 7) check("b2b_second_addend_b", AddendB4, 32'h40000000);
            if (k == 12) check("b2b_second_result", RspResult4, 32'h40800000);
        end
        check("b2b_go_timing", {19'd0, go_mask}, 32'h0041);
        check("b2b_rsp_timing", {19'd0, rsp_mask}, 32'h0820);
        check("b2b_idle_after", Busy4, 0);
        RspReady4 = 1'b0;
        check("b2b_issue_count", IssueCount4, STATS ? 8 : 0);

        // reset in the second WAIT cycle
        ReqA4 = 32'h3F800000; ReqB4 = 32'h40000000; ReqSub4 = 1'b0;
        ReqValid4 = 1'b1;
        @(posedge Clock); #1;
        ReqValid4 = 1'b0;
        @(negedge Clock);
        check("rstmid_go", Go4, 1);
        @(negedge Clock);
        @(posedge Clock); #1;
        Reset = 1'b1;
        #1;
        check("rstmid_busy_go_rsp", {Busy4, Go4, RspValid4}, 0);
        check("rstmid_req_ready", ReqReady4, 1);
        check("rstmid_addends", AddendA4 | AddendB4, 0);
        check("rstmid_rsp", {RspResult4, RspZero4, RspInf4, RspNan4}, 0);
        check("rstmid_counts", {IssueCount4, NanCount4}, 0);
        @(negedge Clock);
        Reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            if (Go4 !== 1'b0 || RspValid4 !== 1'b0) bad++;
        end
        check("rstmid_quiet_after", bad, 0);
        run_vec4(vecs[0], 10);
        check("rstmid_issue_count", IssueCount4, STATS ? 1 : 0);
        check("rstmid_nan_count", NanCount4, 0);

        // combinational adder with a NaN operand
        check("lat0_rst_ready", ReqReady0, 1);
        ReqA0 = 32'h7FC00000; ReqB0 = 32'h3F800000; ReqSub0 = 1'b0;
        ReqValid0 = 1'b1; RspReady0 = 1'b0;
        @(posedge Clock); #1;
        ReqValid0 = 1'b0;
        @(negedge Clock);
        check("lat0_go_rsp_c1", {Go0, RspValid0}, 2'b10);
        @(negedge Clock);
        check("lat0_go_rsp_c2", {Go0, RspValid0}, 2'b01);
        check("lat0_result", RspResult0, 32'h7FC00000);
        check("lat0_flags", {RspZero0, RspInf0, RspNan0}, 3'b001);
        check("lat0_issue_count", IssueCount0, STATS ? 1 : 0);
        check("lat0_nan_count", NanCount0, STATS ? 1 : 0);
        RspReady0 = 1'b1;
        @(posedge Clock); #1;
        RspReady0 = 1'b0;
        @(negedge Clock);
        check("lat0_idle_after", Busy0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
